// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Groups the boot byte stream, the instruction-memory write port and the
// load status lines of the instruction memory loader.
//   in_data/in_valid/in_ready : byte stream from the boot link
//   imem_we/imem_addr/imem_wdata : instruction memory write port
//   cpu_rst/done/error           : core reset (active low) and load status
// Modports:
//   master : the boot link side (drives bytes, observes everything else)
//   slave  : the loader itself
// ---------------------------------------------------------------------------
interface imem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, error
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Write-side companion of the instruction memory. Receives a boot frame as a
// byte stream: LEN_LO, LEN_HI (16-bit word count N), then 4*N payload bytes,
// least significant byte first. Each assembled word is written to the
// instruction memory, and the core is held in reset until the image is in.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : imem_loader_if.slave (byte stream, memory write port, status)
//
// Parameters:
//   DEPTH     : maximum number of words accepted
//   BASE_ADDR : byte address of the first word written (word aligned)
//
// Configuration macro:
//   CHECKSUM_EN : when defined, one extra byte after the payload must equal
//                 the XOR of all payload bytes, otherwise the load fails.
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  typedef enum logic [2:0] {
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
`ifdef CHECKSUM_EN
    ST_CHK,
`endif
    ST_DONE,
    ST_ERR
  } state_t;

  state_t      r_state;
  logic [15:0] r_len;
  logic [15:0] r_wordCnt;
  logic [1:0]  r_byteCnt;
  logic [31:0] r_wdata;
  logic [31:0] r_addr;
  logic        r_we;
  logic        r_ready;
  logic        r_done;
  logic        r_error;
  logic        r_cpuRst;
`ifdef CHECKSUM_EN
  logic [7:0]  r_chk;
`endif

  logic        w_accept;
  logic [15:0] w_lenFull;
  logic        w_lastWord;

  // A byte transfers only when the loader is advertising ready.
  assign w_accept   = bus.in_valid & r_ready;
  assign w_lenFull  = {bus.in_data, r_len[7:0]};
  assign w_lastWord = (r_wordCnt == (r_len - 16'd1));

  // The loader FSM. All outputs are registered. in_ready is updated together
  // with the state so it drops in the very cycle DONE/ERR is entered. The
  // write strobe lasts one cycle, and the address advances when it ends, so
  // a byte accepted during the strobe cycle can already start the next word
  // without disturbing the word being written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_LEN0;
      r_len     <= 16'd0;
      r_wordCnt <= 16'd0;
      r_byteCnt <= 2'd0;
      r_wdata   <= 32'd0;
      r_addr    <= BASE_ADDR;
      r_we      <= 1'b0;
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_cpuRst  <= 1'b0;
`ifdef CHECKSUM_EN
      r_chk     <= 8'd0;
`endif
    end else begin
      r_we <= 1'b0;
      if (r_we) begin
        r_addr <= r_addr + 32'd4;
      end
      case (r_state)
        ST_LEN0: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_len[7:0] <= bus.in_data;
            r_state    <= ST_LEN1;
          end
        end
        ST_LEN1: begin
          if (w_accept) begin
            r_len[15:8] <= bus.in_data;
            if (w_lenFull == 16'd0) begin
`ifdef CHECKSUM_EN
              r_state <= ST_CHK;
`else
              r_state <= ST_DONE;
              r_ready <= 1'b0;
`endif
            end else if ({1'b0, w_lenFull} > DEPTH_L) begin
              r_state <= ST_ERR;
              r_ready <= 1'b0;
              r_error <= 1'b1;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_wdata[{r_byteCnt, 3'b000} +: 8] <= bus.in_data;
            r_byteCnt <= r_byteCnt + 2'd1;
`ifdef CHECKSUM_EN
            r_chk <= r_chk ^ bus.in_data;
`endif
            if (r_byteCnt == 2'd3) begin
              r_we      <= 1'b1;
              r_wordCnt <= r_wordCnt + 16'd1;
              if (w_lastWord) begin
`ifdef CHECKSUM_EN
                r_state <= ST_CHK;
`else
                r_state <= ST_DONE;
                r_ready <= 1'b0;
`endif
              end
            end
          end
        end
`ifdef CHECKSUM_EN
        // The checksum byte may arrive during the last write strobe; done is
        // raised one cycle after acceptance, so it never overlaps that strobe.
        ST_CHK: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            if (bus.in_data == r_chk) begin
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_cpuRst <= 1'b1;
            end else begin
              r_state <= ST_ERR;
              r_error <= 1'b1;
            end
          end
        end
`endif
        // Entered together with the last write strobe, so done and the core
        // reset release appear one cycle after that strobe.
        ST_DONE: begin
          r_ready  <= 1'b0;
          r_done   <= 1'b1;
          r_cpuRst <= 1'b1;
        end
        ST_ERR: begin
          r_ready <= 1'b0;
          r_error <= 1'b1;
        end
        default: begin
          r_state <= ST_ERR;
          r_ready <= 1'b0;
          r_error <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign bus.cpu_rst    = r_cpuRst;
  assign bus.done       = r_done;
  assign bus.error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. A frame-level model turns each byte
// frame into the list of memory writes and final status it must produce; a
// negedge compare process checks every write strobe against that list, plus
// directed literal checks on the resulting memory contents and status.
// Works with and without CHECKSUM_EN defined.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam int          DEPTH     = 1024;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

  logic clk;
  logic rst_n;

  imem_loader_if busIf ();

  imem_loader #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busIf)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int weCount = 0;
  int lastAccCycle = 0;
  int doneCycle = 0;
  bit doneSeen = 0;

  logic [7:0]  frame[$];
  logic [31:0] expAddr[$];
  logic [31:0] expData[$];
  logic [31:0] modelWords[$];
  logic [31:0] mem [0:1023];
  bit          mDone;
  bit          mError;

  // Free-running clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Compare process: runs every cycle away from the active edge, tracks
  // accepted bytes and the done edge, and checks each write strobe against
  // the model's expected write list.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busIf.in_valid && busIf.in_ready) lastAccCycle = cycle;
      if (busIf.done && !doneSeen) begin
        doneSeen  = 1;
        doneCycle = cycle;
      end
      checkOutput("cpuRstEqDone", {31'd0, busIf.cpu_rst}, {31'd0, busIf.done});
      checkOutput("cpuRstDuringWe", {31'd0, busIf.cpu_rst & busIf.imem_we}, 32'd0);
      if (busIf.imem_we === 1'b1) begin
        weCount++;
        mem[busIf.imem_addr[11:2]] = busIf.imem_wdata;
        if (expAddr.size() == 0) begin
          checkOutput("unexpectedWe", 32'd1, 32'd0);
        end else begin
          checkOutput("weAddr", busIf.imem_addr, expAddr.pop_front());
          checkOutput("weData", busIf.imem_wdata, expData.pop_front());
        end
      end
    end
  end

  task automatic sendByte(input logic [7:0] b, input int maxGap);
    int gap;
    bit acc;
    gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
    if (gap > 0) begin
      busIf.in_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    busIf.in_valid = 1'b1;
    busIf.in_data  = b;
    acc = 0;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      acc = busIf.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) checkOutput("acceptTimeout", 32'd0, 32'd1);
  endtask

`ifdef CHECKSUM_EN
  task automatic appendChk();
    logic [7:0] x;
    x = 8'h00;
    for (int j = 2; j < frame.size(); j++) x = x ^ frame[j];
    frame.push_back(x);
  endtask
`endif

  // Frame model: from the word count and payload, derive the writes
  // (address, little-endian word) and the final status, then send the frame.
  task automatic applyStimulus(input int maxGap);
    int n;
    logic [31:0] w;
    logic [7:0]  x;
    n = int'({frame[1], frame[0]});
    mDone  = 0;
    mError = 0;
    modelWords.delete();
    if (n > DEPTH) begin
      mError = 1;
    end else begin
      for (int i = 0; i < n; i++) begin
        if (2 + 4*i + 3 < frame.size()) begin
          w = {frame[2+4*i+3], frame[2+4*i+2], frame[2+4*i+1], frame[2+4*i]};
          expAddr.push_back(BASE_ADDR + 32'(4*i));
          expData.push_back(w);
          modelWords.push_back(w);
        end
      end
`ifdef CHECKSUM_EN
      if (frame.size() > 2 + 4*n) begin
        x = 8'h00;
        for (int j = 0; j < 4*n; j++) x = x ^ frame[2+j];
        if (x == frame[2+4*n]) mDone = 1;
        else mError = 1;
      end
`else
      x = 8'h00;
      mDone = (frame.size() >= 2 + 4*n);
`endif
    end
    foreach (frame[i]) sendByte(frame[i], maxGap);
    busIf.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic checkFinal(input string tag);
    checkOutput({tag, "_done"}, {31'd0, busIf.done}, {31'd0, mDone});
    checkOutput({tag, "_error"}, {31'd0, busIf.error}, {31'd0, mError});
    checkOutput({tag, "_cpuRst"}, {31'd0, busIf.cpu_rst}, {31'd0, mDone});
    checkOutput({tag, "_inReady"}, {31'd0, busIf.in_ready}, {31'd0, !(mDone || mError)});
    checkOutput({tag, "_weCount"}, 32'(weCount), 32'(modelWords.size()));
    checkOutput({tag, "_pendingWrites"}, 32'(expAddr.size()), 32'd0);
    foreach (modelWords[i])
      checkOutput({tag, "_mem"}, mem[BASE_ADDR[11:2] + 10'(i)], modelWords[i]);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_inReady"}, {31'd0, busIf.in_ready}, 32'd0);
    checkOutput({tag, "_we"}, {31'd0, busIf.imem_we}, 32'd0);
    checkOutput({tag, "_addr"}, busIf.imem_addr, BASE_ADDR);
    checkOutput({tag, "_cpuRst"}, {31'd0, busIf.cpu_rst}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, busIf.done}, 32'd0);
    checkOutput({tag, "_error"}, {31'd0, busIf.error}, 32'd0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    busIf.in_valid = 1'b0;
    #1;
    expAddr.delete();
    expData.delete();
    weCount  = 0;
    doneSeen = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 32'hxxxx_xxxx;
    busIf.in_data  = 8'h00;
    busIf.in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    checkResetValues("reset");
    doReset();

    // N=2 contiguous load.
    frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'ha0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
`ifdef CHECKSUM_EN
    frame.push_back(8'h30);
`endif
    applyStimulus(0);
    checkFinal("n2");
    checkOutput("n2_word0", mem[0], 32'h00a00513);
    checkOutput("n2_word1", mem[1], 32'h00100593);
    checkOutput("n2_doneSeen", {31'd0, doneSeen}, 32'd1);
`ifdef CHECKSUM_EN
    checkOutput("n2_doneLatency", 32'(doneCycle - lastAccCycle), 32'd1);
`else
    checkOutput("n2_doneLatency", 32'(doneCycle - lastAccCycle), 32'd2);
`endif
    // Input after DONE must be ignored.
    busIf.in_valid = 1'b1;
    busIf.in_data  = 8'hff;
    repeat (5) @(posedge clk);
    #1;
    busIf.in_valid = 1'b0;
    checkOutput("afterDone_weCount", 32'(weCount), 32'd2);
    checkOutput("afterDone_done", {31'd0, busIf.done}, 32'd1);

    // N=0.
    doReset();
    frame = '{8'h00, 8'h00};
`ifdef CHECKSUM_EN
    frame.push_back(8'h00);
`endif
    applyStimulus(0);
    checkFinal("n0");
    checkOutput("n0_doneLit", {31'd0, busIf.done}, 32'd1);
`ifdef CHECKSUM_EN
    doReset();
    frame = '{8'h00, 8'h00, 8'h01};
    applyStimulus(0);
    checkFinal("n0BadChk");
    checkOutput("n0BadChk_errorLit", {31'd0, busIf.error}, 32'd1);
`endif

    // N=1025 exceeds DEPTH.
    doReset();
    frame = '{8'h01, 8'h04};
    applyStimulus(0);
    checkFinal("tooLong");
    checkOutput("tooLong_errorLit", {31'd0, busIf.error}, 32'd1);
    checkOutput("tooLong_inReadyLit", {31'd0, busIf.in_ready}, 32'd0);

    // N=3 with random gaps between bytes.
    doReset();
    frame = '{8'h03, 8'h00, 8'hde, 8'had, 8'hbe, 8'hef, 8'h01, 8'h23, 8'h45, 8'h67,
              8'h89, 8'hab, 8'hcd, 8'hef};
`ifdef CHECKSUM_EN
    appendChk();
`endif
    applyStimulus(3);
    checkFinal("gaps");
    checkOutput("gaps_word0", mem[0], 32'hefbeadde);
    checkOutput("gaps_word2", mem[2], 32'hefcdab89);

    // Reset after 6 payload bytes, then reload a fresh frame.
    doReset();
    frame = '{8'h02, 8'h00, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22};
    applyStimulus(0);
    checkOutput("midLoad_weCount", 32'(weCount), 32'd1);
    rst_n = 1'b0;
    #1;
    checkResetValues("midLoad");
    doReset();
    frame = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hf0, 8'hde, 8'hbc, 8'h9a};
`ifdef CHECKSUM_EN
    appendChk();
`endif
    applyStimulus(0);
    checkFinal("reload");
    checkOutput("reload_word0", mem[0], 32'h12345678);
    checkOutput("reload_word1", mem[1], 32'h9abcdef0);

`ifdef CHECKSUM_EN
    // Checksum match and mismatch with a single word.
    doReset();
    frame = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    applyStimulus(0);
    checkFinal("chkOk");
    checkOutput("chkOk_doneLit", {31'd0, busIf.done}, 32'd1);
    doReset();
    mem[0] = 32'h0;
    frame = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    applyStimulus(0);
    checkFinal("chkBad");
    checkOutput("chkBad_errorLit", {31'd0, busIf.error}, 32'd1);
    checkOutput("chkBad_cpuRstLit", {31'd0, busIf.cpu_rst}, 32'd0);
    checkOutput("chkBad_word", mem[0], 32'h44332211);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
